uart_bus_arbiter: RTL and testbench

- Shares the UART host register bus (chip select, address, read/write, bidirectional data) between two on-chip requesters, e.g. a CPU port and a DMA/config engine.
- Serializes accesses with round-robin arbitration.
- Generates the CS/RW timing that the UART's internal posedge detectors require: CS held low, then a mandatory CS-high recovery gap so every access produces exactly one read/write pulse.
- Captures read data for the granted requester.

---
 rtl/uart_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_bus_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART host register bus between two requesters.
// Each access is SETUP, HOLD_CYCLES of CS low, then RECOVERY_CYCLES of CS high.
module uart_bus_arbiter #(
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic [1:0] we_i,
    input  logic [2:0] addr0_i,
    input  logic [2:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       uart_cs_n_o,
    output logic       uart_rw_o,
    output logic [2:0] uart_addr_o,
    output logic [7:0] uart_data_o,
    output logic       uart_data_oe_o,
    input  logic [7:0] uart_data_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] REC_LAST  = 4'(RECOVERY_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       winner;
    logic       access_end;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req_i == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req_i[1];
        end
    end

    assign access_end = (state_q == ACCESS) && (cnt_q == HOLD_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Requester inputs are only sampled at grant; the latched copies drive the bus.
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if ((state_q == IDLE) && (|req_i)) begin
            owner_d = winner;
            we_d    = we_i[winner];
            addr_d  = winner ? addr1_i : addr0_i;
            wdata_d = winner ? wdata1_i : wdata0_i;
        end
        if (access_end) begin
            last_d = owner_q;
            if (!we_q) begin
                rdata_d = uart_data_i;
            end
        end
    end

    always_comb begin
        gnt_o          = '0;
        done_o         = '0;
        busy_o         = (state_q != IDLE);
        uart_cs_n_o    = (state_q != ACCESS);
        uart_rw_o      = ~we_q;
        uart_addr_o    = addr_q;
        uart_data_o    = wdata_q;
        uart_data_oe_o = 1'b0;
        rdata_o        = rdata_q;
        if ((state_q == SETUP) || (state_q == ACCESS)) begin
            gnt_o          = owner_q ? 2'b10 : 2'b01;
            uart_data_oe_o = we_q;
        end
        if ((state_q == RECOVER) && (cnt_q == 4'd0)) begin
            done_o = owner_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: vector table of single accesses plus
// sequences for reset mid-access, round-robin streaming and a short-timing instance.
module tb_uart_bus_arbiter;

    localparam int HOLD = 4;
    localparam int REC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0, we = '0;
    logic [2:0] a0 = '0, a1 = '0;
    logic [7:0] w0 = '0, w1 = '0, udi = '0;
    logic [1:0] gnt, done;
    logic [7:0] rdata, udo;
    logic       busy, cs_n, rw, oe;
    logic [2:0] uaddr;

    logic [1:0] p_req = '0, p_we = '0;
    logic [2:0] p_a0 = '0, p_a1 = '0;
    logic [7:0] p_w0 = '0, p_w1 = '0, p_udi = '0;
    logic [1:0] p_gnt, p_done;
    logic [7:0] p_rdata, p_udo;
    logic       p_busy, p_cs_n, p_rw, p_oe;
    logic [2:0] p_uaddr;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    uart_bus_arbiter u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we),
        .addr0_i(a0), .addr1_i(a1), .wdata0_i(w0), .wdata1_i(w1),
        .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
        .uart_cs_n_o(cs_n), .uart_rw_o(rw), .uart_addr_o(uaddr),
        .uart_data_o(udo), .uart_data_oe_o(oe), .uart_data_i(udi)
    );

    uart_bus_arbiter #(.HOLD_CYCLES(3), .RECOVERY_CYCLES(1)) u_dut_p (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(p_req), .we_i(p_we),
        .addr0_i(p_a0), .addr1_i(p_a1), .wdata0_i(p_w0), .wdata1_i(p_w1),
        .gnt_o(p_gnt), .done_o(p_done), .rdata_o(p_rdata), .busy_o(p_busy),
        .uart_cs_n_o(p_cs_n), .uart_rw_o(p_rw), .uart_addr_o(p_uaddr),
        .uart_data_o(p_udo), .uart_data_oe_o(p_oe), .uart_data_i(p_udi)
    );

    // Continuous contention / one-hot invariants, tallied and compared once at the end.
    always @(negedge clk) begin
        if (oe && (rw || gnt == 2'b00)) viol++;
        if (p_oe && (p_rw || p_gnt == 2'b00)) viol++;
        if ($countones(gnt) > 1 || $countones(done) > 1) viol++;
        if ($countones(p_gnt) > 1 || $countones(p_done) > 1) viol++;
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] udi;
        logic [1:0] gnt;
        logic       rw;
        logic [2:0] addr;
        logic [7:0] data;
        logic       oe;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        req = v.req; we = v.we; a0 = v.a0; a1 = v.a1; w0 = v.w0; w1 = v.w1;
        udi = ~v.udi;
        tick();
        check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v.gnt));
        check($sformatf("v%0d_setup_cs", i), 32'(cs_n), 32'd1);
        check($sformatf("v%0d_addr", i), 32'(uaddr), 32'(v.addr));
        check($sformatf("v%0d_rw", i), 32'(rw), 32'(v.rw));
        check($sformatf("v%0d_oe", i), 32'(oe), 32'(v.oe));
        if (v.oe) check($sformatf("v%0d_data", i), 32'(udo), 32'(v.data));
        we = ~v.we; a0 = ~v.a0; a1 = ~v.a1; w0 = ~v.w0; w1 = ~v.w1;
        for (int c = 0; c < HOLD; c++) begin
            tick();
            if (c == HOLD - 1) udi = v.udi;
            check($sformatf("v%0d_acc%0d_cs", i, c), 32'(cs_n), 32'd0);
            check($sformatf("v%0d_acc%0d_bus", i, c), {gnt, rw, oe, uaddr},
                  {v.gnt, v.rw, v.oe, v.addr});
        end
        tick();
        check($sformatf("v%0d_done", i), 32'(done), 32'(v.gnt));
        check($sformatf("v%0d_rec_bus", i), {gnt, cs_n, oe}, {2'b00, 1'b1, 1'b0});
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v.rdata));
        req = '0;
        udi = 8'h00;
        tick();
        check($sformatf("v%0d_done_clr", i), {done, cs_n}, {2'b00, 1'b1});
        tick();
        check($sformatf("v%0d_idle", i), {busy, rdata}, {1'b0, v.rdata});
    endtask

    initial begin
        logic [1:0] order[4];
        int         gtime[4];
        int         ng, cyc, run, bad, pulses, ndone;
        logic [1:0] prev_gnt;
        logic       prev_cs, prev_done;

        vecs[0] = '{2'b01, 2'b01, 3'd2, 3'd0, 8'hA5, 8'h00, 8'h00, 2'b01, 1'b0, 3'd2, 8'hA5, 1'b1, 8'h00};
        vecs[1] = '{2'b10, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h3C, 2'b10, 1'b1, 3'd0, 8'h00, 1'b0, 8'h3C};
        vecs[2] = '{2'b11, 2'b11, 3'd5, 3'd6, 8'h11, 8'h22, 8'h00, 2'b01, 1'b0, 3'd5, 8'h11, 1'b1, 8'h3C};
        vecs[3] = '{2'b11, 2'b10, 3'd1, 3'd7, 8'h00, 8'h77, 8'h99, 2'b10, 1'b0, 3'd7, 8'h77, 1'b1, 8'h3C};
        vecs[4] = '{2'b11, 2'b00, 3'd4, 3'd3, 8'h00, 8'h00, 8'h5A, 2'b01, 1'b1, 3'd4, 8'h00, 1'b0, 8'h5A};
        vecs[5] = '{2'b01, 2'b00, 3'd6, 3'd1, 8'h00, 8'h00, 8'hC3, 2'b01, 1'b1, 3'd6, 8'h00, 1'b0, 8'hC3};

        #12;
        check("reset_ctl", {gnt, done, busy, rdata}, 13'd0);
        check("reset_bus", {cs_n, rw, uaddr, udo, oe}, {1'b1, 1'b1, 3'd0, 8'd0, 1'b0});
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset asserted during the third ACCESS cycle of a write.
        req = 2'b01; we = 2'b01; a0 = 3'd3; w0 = 8'h5C;
        tick(); tick(); tick(); tick();
        check("pre_reset_cs", {cs_n, oe}, {1'b0, 1'b1});
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {cs_n, oe, gnt, done, busy}, {1'b1, 1'b0, 2'b00, 2'b00, 1'b0});
        req = 2'b11; we = 2'b00;
        #3;
        rst_n = 1'b1;

        ng = 0; cyc = 0; run = 0; bad = 0; prev_gnt = '0;
        for (int k = 0; k < 4; k++) begin order[k] = '0; gtime[k] = 0; end
        for (int n = 0; n < 40; n++) begin
            tick();
            cyc++;
            if (gnt != 2'b00 && prev_gnt == 2'b00 && ng < 4) begin
                order[ng] = gnt; gtime[ng] = cyc; ng++;
            end
            prev_gnt = gnt;
            if (!cs_n) run++;
            else begin
                if (run != 0 && run != HOLD) bad++;
                run = 0;
            end
        end
        req = '0;
        check("rr_ngrants", 32'(ng), 32'd4);
        check("rr_first_after_reset", 32'(order[0]), 32'd1);
        check("rr_order1", 32'(order[1]), 32'd2);
        check("rr_order2", 32'(order[2]), 32'd1);
        check("rr_order3", 32'(order[3]), 32'd2);
        for (int k = 1; k < 4; k++)
            check($sformatf("rr_interval%0d", k), 32'(gtime[k] - gtime[k-1]), 32'd8);
        check("rr_cs_runs", 32'(bad), 32'd0);
        for (int n = 0; n < 10; n++) tick();
        check("rr_idle", 32'(busy), 32'd0);

        // Requester 0 streaming; requester 1 arrives mid-access.
        req = 2'b01; we = 2'b00; a0 = 3'd1; a1 = 3'd2;
        tick();
        check("st_first", 32'(gnt), 32'd1);
        tick(); tick();
        req = 2'b11;
        ng = 0; prev_gnt = gnt;
        for (int k = 0; k < 4; k++) order[k] = '0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00 && ng < 2) begin
                order[ng] = gnt; ng++;
            end
            prev_gnt = gnt;
        end
        req = '0;
        check("st_req1_next", 32'(order[0]), 32'd2);
        check("st_req0_after", 32'(order[1]), 32'd1);
        for (int n = 0; n < 10; n++) tick();

        // Short-timing instance: two back-to-back writes to the TX register.
        p_req = 2'b01; p_we = 2'b01; p_a0 = 3'd0; p_w0 = 8'h41;
        ng = 0; cyc = 0; run = 0; bad = 0; pulses = 0; ndone = 0;
        prev_gnt = '0; prev_cs = 1'b1; prev_done = 1'b0;
        for (int k = 0; k < 4; k++) gtime[k] = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            cyc++;
            if (p_gnt != 2'b00 && prev_gnt == 2'b00 && ng < 4) begin
                gtime[ng] = cyc; ng++;
            end
            prev_gnt = p_gnt;
            if (prev_cs == 1'b0 && p_cs_n == 1'b1 && p_rw == 1'b0) pulses++;
            prev_cs = p_cs_n;
            if (!p_cs_n) run++;
            else begin
                if (run != 0 && run != 3) bad++;
                run = 0;
            end
            if (p_done != 2'b00 && !prev_done) begin
                ndone++;
                if (ndone == 2) p_req = '0;
            end
            prev_done = (p_done != 2'b00);
        end
        check("p_grants", 32'(ng), 32'd2);
        check("p_interval", 32'(gtime[1] - gtime[0]), 32'd6);
        check("p_done_count", 32'(ndone), 32'd2);
        check("p_write_pulses", 32'(pulses), 32'd2);
        check("p_cs_runs", 32'(bad), 32'd0);
        check("p_idle", 32'(p_busy), 32'd0);

        check("bus_invariants", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
